// File: rtl/carryn_alu_pkg.sv
// carryn_alu shared types: opcodes, FSM states and slice-count helper.
// Used by carryn_alu and carryn_alu_slice.
package carryn_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADC = 3'b001,
    OP_SBC = 3'b010,
    OP_AND = 3'b011,
    OP_ORR = 3'b100,
    OP_EOR = 3'b101,
    OP_SEL = 3'b110,
    OP_SEH = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int slices(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic logic is_arith(input opcode_t op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/carryn_alu_slice.sv
// carryn_alu_slice: combinational SLICE-bit op unit.
// Exposes carry-out and carry into the slice MSB for the V flag.
module carryn_alu_slice
  import carryn_alu_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  opcode_t          opcode,
  input  logic             cin,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] res,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE-1:0] bb;
  logic [SLICE-1:0] sum;
  logic             carry;

  always_comb begin
    bb    = (opcode == OP_SBC) ? ~b : b;
    sum   = '0;
    cmsb  = 1'b0;
    carry = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ bb[i] ^ carry;
      if (i == SLICE - 1) cmsb = carry;
      carry = (a[i] & bb[i]) | (carry & (a[i] ^ bb[i]));
    end
    cout = carry;
  end

  always_comb begin
    unique case (opcode)
      OP_ADC, OP_SBC: res = sum;
      OP_AND:         res = a & b;
      OP_ORR:         res = a | b;
      OP_EOR:         res = a ^ b;
      OP_SEL:         res = a;
      OP_SEH:         res = b;
      default:        res = '0;
    endcase
  end

endmodule

// File: rtl/carryn_alu.sv
// carryn_alu: multi-cycle slice-serial ALU with valid/ready and abort.
// CARRYN_ALU_FASTLOGIC_EN: non-arithmetic ops finish in one RUN cycle.
module carryn_alu
  import carryn_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             rx_valid,
  output logic             tx_ready,
  input  opcode_t          rx_opcode,
  input  logic             rx_carryflag,
  input  logic [WIDTH-1:0] rx_operand0,
  input  logic [WIDTH-1:0] rx_operand1,
  input  logic             rx_abort,
  output logic             tx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] tx_result,
  output logic             tx_carryflag,
  output logic             tx_zeroflag,
  output logic             tx_signflag,
  output logic             tx_overflowflag
);

  localparam int SLICES = slices(WIDTH, SLICE);
  localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  if ((WIDTH % SLICE) != 0 || SLICES < 2) begin : g_chk
    $error("carryn_alu: WIDTH must be a multiple of SLICE, SLICES >= 2");
  end

  state_t           state;
  logic [IW-1:0]    idx;
  opcode_t          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;

  logic [SLICE-1:0] s_res;
  logic             s_cout;
  logic             s_cmsb;
  logic [WIDTH-1:0] word_n;
  logic             last;
  logic             arith;

  assign tx_ready = aresetn && (state == IDLE);
  assign arith    = is_arith(op_q);

  carryn_alu_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .opcode (op_q),
    .cin    (carry_q),
    .a      (a_q[idx*SLICE +: SLICE]),
    .b      (b_q[idx*SLICE +: SLICE]),
    .res    (s_res),
    .cout   (s_cout),
    .cmsb   (s_cmsb)
  );

  always_comb begin
    word_n = acc_q;
    word_n[idx*SLICE +: SLICE] = s_res;
    last = (idx == LAST);
`ifdef CARRYN_ALU_FASTLOGIC_EN
    if (!arith) begin
      last = 1'b1;
      unique case (op_q)
        OP_AND:  word_n = a_q & b_q;
        OP_ORR:  word_n = a_q | b_q;
        OP_EOR:  word_n = a_q ^ b_q;
        OP_SEL:  word_n = a_q;
        OP_SEH:  word_n = b_q;
        default: word_n = '0;
      endcase
    end
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      idx             <= '0;
      op_q            <= OP_NOP;
      a_q             <= '0;
      b_q             <= '0;
      acc_q           <= '0;
      carry_q         <= 1'b0;
      tx_valid        <= 1'b0;
      tx_result       <= '0;
      tx_carryflag    <= 1'b0;
      tx_zeroflag     <= 1'b0;
      tx_signflag     <= 1'b0;
      tx_overflowflag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            op_q    <= rx_opcode;
            a_q     <= rx_operand0;
            b_q     <= rx_operand1;
            carry_q <= rx_carryflag;
            acc_q   <= '0;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // abort beats completion; published result stays untouched
          if (rx_abort) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            acc_q   <= word_n;
            carry_q <= s_cout;
            idx     <= idx + 1'b1;
            if (last) begin
              idx             <= '0;
              state           <= DONE;
              tx_valid        <= 1'b1;
              tx_result       <= word_n;
              tx_carryflag    <= arith & s_cout;
              tx_overflowflag <= arith & (s_cout ^ s_cmsb);
              tx_zeroflag     <= (word_n == '0);
              tx_signflag     <= word_n[WIDTH-1];
            end
          end
        end
        DONE: begin
          if (rx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carryn_alu.sv
// Self-checking bench for carryn_alu (16/2 and 8/4 instances).
// Vector table, random ops vs arithmetic model, handshake corner cases.
module tb_carryn_alu;
  import carryn_alu_pkg::*;

`ifdef CARRYN_ALU_FASTLOGIC_EN
  localparam int LOGIC_LAT = 1;
`else
  localparam int LOGIC_LAT = 8;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        rx_valid, tx_ready, rx_carryflag, rx_abort;
  logic        tx_valid, rx_ready;
  opcode_t     rx_opcode;
  logic [15:0] rx_operand0, rx_operand1, tx_result;
  logic        tx_carryflag, tx_zeroflag, tx_signflag, tx_overflowflag;

  logic        rx_valid8, tx_ready8, rx_carryflag8, rx_abort8;
  logic        tx_valid8, rx_ready8;
  opcode_t     rx_opcode8;
  logic [7:0]  rx_operand0_8, rx_operand1_8, tx_result8;
  logic        tx_carryflag8, tx_zeroflag8, tx_signflag8, tx_overflowflag8;

  carryn_alu #(.WIDTH(16), .SLICE(2)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .rx_valid        (rx_valid),
    .tx_ready        (tx_ready),
    .rx_opcode       (rx_opcode),
    .rx_carryflag    (rx_carryflag),
    .rx_operand0     (rx_operand0),
    .rx_operand1     (rx_operand1),
    .rx_abort        (rx_abort),
    .tx_valid        (tx_valid),
    .rx_ready        (rx_ready),
    .tx_result       (tx_result),
    .tx_carryflag    (tx_carryflag),
    .tx_zeroflag     (tx_zeroflag),
    .tx_signflag     (tx_signflag),
    .tx_overflowflag (tx_overflowflag)
  );

  carryn_alu #(.WIDTH(8), .SLICE(4)) dut8 (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .rx_valid        (rx_valid8),
    .tx_ready        (tx_ready8),
    .rx_opcode       (rx_opcode8),
    .rx_carryflag    (rx_carryflag8),
    .rx_operand0     (rx_operand0_8),
    .rx_operand1     (rx_operand1_8),
    .rx_abort        (rx_abort8),
    .tx_valid        (tx_valid8),
    .rx_ready        (rx_ready8),
    .tx_result       (tx_result8),
    .tx_carryflag    (tx_carryflag8),
    .tx_zeroflag     (tx_zeroflag8),
    .tx_signflag     (tx_signflag8),
    .tx_overflowflag (tx_overflowflag8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    opcode_t     op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic [3:0]  f;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] flags16();
    return {tx_carryflag, tx_zeroflag, tx_signflag, tx_overflowflag};
  endfunction

  // reference: plain integer arithmetic, flags returned as {C,Z,N,V}
  function automatic logic [19:0] model(input opcode_t op,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic cin);
    logic [16:0] full;
    logic [15:0] bo, r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      OP_ADC, OP_SBC: begin
        bo   = (op == OP_SBC) ? ~b : b;
        full = {1'b0, a} + {1'b0, bo} + 17'(cin);
        r    = full[15:0];
        c    = full[16];
        v    = (a[15] == bo[15]) && (r[15] != a[15]);
      end
      OP_AND: r = a & b;
      OP_ORR: r = a | b;
      OP_EOR: r = a ^ b;
      OP_SEL: r = a;
      OP_SEH: r = b;
      default: r = '0;
    endcase
    return {r, c, (r == 16'h0), r[15], v};
  endfunction

  function automatic int lat_of(input opcode_t op);
    return (op == OP_ADC || op == OP_SBC) ? 8 : LOGIC_LAT;
  endfunction

  task automatic issue(input opcode_t op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    check("accept_ready", 32'(tx_ready), 1);
    rx_valid     = 1'b1;
    rx_opcode    = op;
    rx_operand0  = a;
    rx_operand1  = b;
    rx_carryflag = cin;
    @(negedge aclk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge aclk);
      n++;
    end
  endtask

  task automatic run_one(input string name, input opcode_t op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] res,
                         input logic [3:0] f);
    int n;
    issue(op, a, b, cin);
    wait_valid(n);
    check({name, "_lat"}, 32'(n), 32'(lat_of(op)));
    check({name, "_res"}, 32'(tx_result), 32'(res));
    check({name, "_flags"}, 32'(flags16()), 32'(f));
    rx_ready = 1'b1;
    @(negedge aclk);
    rx_ready = 1'b0;
    check({name, "_drop"}, 32'(tx_valid), 0);
  endtask

  task automatic run_model(input string name, input opcode_t op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
    logic [19:0] e;
    e = model(op, a, b, cin);
    run_one(name, op, a, b, cin, e[19:4], e[3:0]);
  endtask

  task automatic check_held(input string name, input logic [15:0] res,
                            input logic [3:0] f);
    check({name, "_ready"}, 32'(tx_ready), 1);
    check({name, "_valid"}, 32'(tx_valid), 0);
    check({name, "_res"}, 32'(tx_result), 32'(res));
    check({name, "_flags"}, 32'(flags16()), 32'(f));
    repeat (12) @(negedge aclk);
    check({name, "_late"}, 32'(tx_valid), 0);
  endtask

  initial begin
    int n;
    logic [19:0] e;
    opcode_t op;

    vt[0] = '{OP_ADC, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1100};
    vt[1] = '{OP_SBC, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1001};
    vt[2] = '{OP_SBC, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0010};
    vt[3] = '{OP_EOR, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 4'b0000};
    vt[4] = '{OP_SEH, 16'h1234, 16'hBEEF, 1'b0, 16'hBEEF, 4'b0010};
    vt[5] = '{OP_NOP, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b0100};
    vt[6] = '{OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0011};
    vt[7] = '{OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 4'b0000};
    vt[8] = '{OP_SEL, 16'h8001, 16'h0000, 1'b0, 16'h8001, 4'b0010};
    vt[9] = '{OP_ORR, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 4'b0000};

    rx_valid = 0; rx_opcode = OP_NOP; rx_carryflag = 0; rx_abort = 0;
    rx_ready = 0; rx_operand0 = 0; rx_operand1 = 0;
    rx_valid8 = 0; rx_opcode8 = OP_NOP; rx_carryflag8 = 0; rx_abort8 = 0;
    rx_ready8 = 0; rx_operand0_8 = 0; rx_operand1_8 = 0;

    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_res", 32'(tx_result), 0);
    check("rst_flags", 32'(flags16()), 0);
    check("rst8_ready", 32'(tx_ready8), 1);

    for (int i = 0; i < 10; i++)
      run_one($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
              vt[i].cin, vt[i].res, vt[i].f);

    for (int i = 0; i < 40; i++) begin
      op = opcode_t'($urandom_range(0, 7));
      run_model($sformatf("rnd%0d", i), op, 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)));
    end

    // backpressure: DONE held, new request must not be taken
    issue(OP_ADC, 16'h1234, 16'h4321, 1'b0);
    wait_valid(n);
    check("bp_lat", 32'(n), 8);
    for (int k = 0; k < 5; k++) begin
      rx_valid    = 1'b1;
      rx_opcode   = OP_SEH;
      rx_operand0 = 16'(k);
      rx_operand1 = 16'hFFFF;
      @(negedge aclk);
      check("bp_valid", 32'(tx_valid), 1);
      check("bp_ready", 32'(tx_ready), 0);
      check("bp_res", 32'(tx_result), 32'h5555);
    end
    rx_valid = 1'b0;
    rx_ready = 1'b1;
    @(negedge aclk);
    rx_ready = 1'b0;
    check("bp_idle", 32'(tx_ready), 1);
    repeat (10) @(negedge aclk);
    check("bp_noaccept", 32'(tx_valid), 0);

    // abort at slice 3
    run_model("pre_abort", OP_SBC, 16'h0000, 16'h0001, 1'b1);
    issue(OP_ADC, 16'h0F0F, 16'h0101, 1'b0);
    repeat (3) @(negedge aclk);
    rx_abort = 1'b1;
    @(negedge aclk);
    rx_abort = 1'b0;
    check_held("abort3", 16'hFFFF, 4'b0010);

    // abort coincident with the final slice
    issue(OP_ADC, 16'h0F0F, 16'h0101, 1'b0);
    repeat (7) @(negedge aclk);
    rx_abort = 1'b1;
    @(negedge aclk);
    rx_abort = 1'b0;
    check_held("abort7", 16'hFFFF, 4'b0010);

    run_model("post_abort", OP_ADC, 16'h1111, 16'h2222, 1'b0);

    // async reset mid-operation
    issue(OP_SBC, 16'h8000, 16'h0001, 1'b1);
    repeat (5) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid), 0);
    check("arst_res", 32'(tx_result), 0);
    check("arst_flags", 32'(flags16()), 0);
    check("arst_ready", 32'(tx_ready), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("arst_rel_ready", 32'(tx_ready), 1);
    repeat (12) @(negedge aclk);
    check("arst_no_partial", 32'(tx_valid), 0);
    run_model("post_reset", OP_ADC, 16'hFFFF, 16'hFFFF, 1'b1);

    // WIDTH=8 SLICE=4 instance
    check("w8_ready", 32'(tx_ready8), 1);
    rx_valid8     = 1'b1;
    rx_opcode8    = OP_ADC;
    rx_operand0_8 = 8'h7F;
    rx_operand1_8 = 8'h01;
    rx_carryflag8 = 1'b0;
    @(negedge aclk);
    rx_valid8 = 1'b0;
    n = 0;
    while (!tx_valid8 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("w8_lat", 32'(n), 2);
    check("w8_res", 32'(tx_result8), 32'h80);
    check("w8_flags", 32'({tx_carryflag8, tx_zeroflag8, tx_signflag8,
                           tx_overflowflag8}), 32'b0011);
    rx_ready8 = 1'b1;
    @(negedge aclk);
    rx_ready8 = 1'b0;
    check("w8_drop", 32'(tx_valid8), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
